// File: rtl/mac_rx_frame_reader.sv
// Drains one MAC port's RX pointer/data FIFOs into the switch core as a valid/ready byte stream.
// Bad frames are read out and discarded; good and dropped frames are counted with saturation.
module mac_rx_frame_reader #(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 60
) (
    input  logic        clk,
    input  logic        rstn_sys,
    output logic        rx_ptr_fifo_rd,
    input  logic [15:0] rx_ptr_fifo_dout,
    input  logic        rx_ptr_fifo_empty,
    output logic        rx_data_fifo_rd,
    input  logic [7:0]  rx_data_fifo_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic [15:0] frm_cnt,
    output logic [15:0] drop_cnt,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    // Handshake: a byte moves on every rising clk edge where out_valid && out_ready;
    // once out_valid rises, out_data/out_sop/out_eop hold until that edge.

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PTR  = 2'd1;
    localparam logic [1:0] S_FWD  = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [11:0] MAX_L = 12'(MAX_LEN);
    localparam logic [11:0] MIN_L = 12'(MIN_LEN);

    logic [1:0]  state;
    logic [11:0] len;
    logic [11:0] rem;
    logic        inflight;
    logic        infl_sop;
    logic        infl_eop;
    logic [9:0]  buf_mem [2];
    logic        rd_idx;
    logic        wr_idx;
    logic [1:0]  occ;
    logic        pop;
    logic        push;
    logic        fwd_rd;
    logic        drop_evt;
    logic [11:0] ptr_len;
    logic        ptr_err;
    logic        ptr_rsvd_unused;
    logic [9:0]  head;

    assign ptr_len         = rx_ptr_fifo_dout[11:0];
    assign ptr_err         = rx_ptr_fifo_dout[15];
    assign ptr_rsvd_unused = ^rx_ptr_fifo_dout[14:12];

    assign pop  = (occ != 2'd0) && out_ready;
    assign push = inflight;

    // Counting the same-cycle pop keeps a 1 byte/cycle stream while never overfilling the buffer.
    always_comb begin
        fwd_rd = 1'b0;
        if (state == S_FWD && rem != 12'd0)
            fwd_rd = (({1'b0, occ} + {2'b0, inflight}) - {2'b0, pop}) < 3'd2;
    end

    always_comb begin
        drop_evt = 1'b0;
        if (state == S_PTR && ptr_len == 12'd0)
            drop_evt = 1'b1;
        else if (state == S_DROP && rem == 12'd1)
            drop_evt = 1'b1;
    end

    assign rx_ptr_fifo_rd  = (state == S_IDLE) && !rx_ptr_fifo_empty;
    assign rx_data_fifo_rd = fwd_rd || (state == S_DROP && rem != 12'd0);

    always_ff @(posedge clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state <= S_IDLE;
            len   <= 12'd0;
            rem   <= 12'd0;
        end else begin
            case (state)
                S_IDLE: if (!rx_ptr_fifo_empty) state <= S_PTR;
                S_PTR: begin
                    len <= ptr_len;
                    rem <= ptr_len;
                    if (ptr_len == 12'd0)
                        state <= S_IDLE;
                    else if (ptr_err || ptr_len > MAX_L || ptr_len < MIN_L)
                        state <= S_DROP;
                    else
                        state <= S_FWD;
                end
                S_FWD: if (fwd_rd) begin
                    rem <= rem - 12'd1;
                    if (rem == 12'd1) state <= S_IDLE;
                end
                default: begin
                    rem <= rem - 12'd1;
                    if (rem == 12'd1) state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            inflight <= 1'b0;
            infl_sop <= 1'b0;
            infl_eop <= 1'b0;
            rd_idx   <= 1'b0;
            wr_idx   <= 1'b0;
            occ      <= 2'd0;
            frm_cnt  <= 16'd0;
            drop_cnt <= 16'd0;
        end else begin
            inflight <= fwd_rd;
            infl_sop <= fwd_rd && (rem == len);
            infl_eop <= fwd_rd && (rem == 12'd1);
            if (push) wr_idx <= ~wr_idx;
            if (pop)  rd_idx <= ~rd_idx;
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop && head[0] && frm_cnt != 16'hFFFF)
                frm_cnt <= frm_cnt + 16'd1;
            if (drop_evt && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) buf_mem[wr_idx] <= {rx_data_fifo_dout, infl_sop, infl_eop};
    end

    // Buffer storage is not reset, so the head is masked while empty.
    assign head      = (occ != 2'd0) ? buf_mem[rd_idx] : 10'd0;
    assign out_valid = (occ != 2'd0);
    assign out_data  = head[9:2];
    assign out_sop   = head[1];
    assign out_eop   = head[0];
    assign busy      = (state != S_IDLE) || (occ != 2'd0) || inflight;
    assign fsm_state = state;

endmodule

// File: tb/tb_mac_rx_frame_reader.sv
// Self-checking bench for mac_rx_frame_reader: behavioural RX FIFOs, scoreboard of expected bytes.
module tb_mac_rx_frame_reader;

    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 60;

    logic        clk;
    logic        rstn_sys;
    logic        rx_ptr_fifo_rd;
    logic [15:0] rx_ptr_fifo_dout;
    logic        rx_ptr_fifo_empty;
    logic        rx_data_fifo_rd;
    logic [7:0]  rx_data_fifo_dout;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic [15:0] frm_cnt;
    logic [15:0] drop_cnt;
    logic        busy;
    logic [1:0]  fsm_state;

    mac_rx_frame_reader #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .clk               (clk),
        .rstn_sys          (rstn_sys),
        .rx_ptr_fifo_rd    (rx_ptr_fifo_rd),
        .rx_ptr_fifo_dout  (rx_ptr_fifo_dout),
        .rx_ptr_fifo_empty (rx_ptr_fifo_empty),
        .rx_data_fifo_rd   (rx_data_fifo_rd),
        .rx_data_fifo_dout (rx_data_fifo_dout),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_sop           (out_sop),
        .out_eop           (out_eop),
        .frm_cnt           (frm_cnt),
        .drop_cnt          (drop_cnt),
        .busy              (busy),
        .fsm_state         (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural RX FIFOs with 1-cycle read latency
    logic [15:0] ptr_mem  [64];
    logic [7:0]  data_mem [4096];
    int ptr_pushed  = 0;
    int ptr_popped  = 0;
    int data_pushed = 0;
    int data_popped = 0;

    assign rx_ptr_fifo_empty = (ptr_pushed == ptr_popped);

    always @(posedge clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            ptr_popped  <= ptr_pushed;
            data_popped <= data_pushed;
            rx_ptr_fifo_dout  <= 16'd0;
            rx_data_fifo_dout <= 8'd0;
        end else begin
            if (rx_ptr_fifo_rd) begin
                rx_ptr_fifo_dout <= ptr_mem[ptr_popped % 64];
                ptr_popped <= ptr_popped + 1;
            end
            if (rx_data_fifo_rd) begin
                rx_data_fifo_dout <= data_mem[data_popped % 4096];
                data_popped <= data_popped + 1;
            end
        end
    end

    // scoreboard state
    logic [9:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int exp_frm  = 0;
    int exp_drop = 0;
    int n_acc    = 0;
    int cyc      = 0;
    int ready_mode = 0;
    logic gap_mode = 1'b0;
    logic have_eop = 1'b0;
    int last_eop_cyc = 0;
    int sop_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: pat 0 = ascending bytes, 1 = 0x80 + index, 2 = random
    task automatic push_frame(input logic [15:0] ptr, input int pat);
        int len;
        logic [7:0] b;
        logic good;
        len  = int'(ptr[11:0]);
        good = !ptr[15] && len >= MIN_LEN && len <= MAX_LEN;
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            if (pat == 0)      b = 8'(i);
            else if (pat == 1) b = 8'(8'h80 + i);
            else               b = 8'($urandom_range(0, 255));
            data_mem[data_pushed % 4096] = b;
            data_pushed++;
            if (good) exp_q.push_back({b, (i == 0), (i == len - 1)});
        end
        ptr_mem[ptr_pushed % 64] = ptr;
        ptr_pushed++;
        if (good) exp_frm++;
        else      exp_drop++;
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic monitor();
        logic       stalled;
        logic [9:0] held;
        logic [9:0] cur;
        logic [9:0] e;
        stalled = 1'b0;
        held    = 10'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn_sys) begin
                stalled = 1'b0;
                continue;
            end
            cur = {out_data, out_sop, out_eop};
            if (stalled) begin
                check_eq("stall_valid", 32'(out_valid), 1);
                check_eq("stall_hold", 32'(cur), 32'(held));
            end
            if (rx_data_fifo_rd)
                check_eq("data_avail", 32'(data_popped != data_pushed), 1);
            if (out_valid && out_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", 32'(exp_q.size() != 0), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("byte", 32'(cur), 32'(e));
                end
                if (gap_mode) begin
                    if (out_sop) begin
                        if (have_eop) check_eq("frame_gap", 32'(cyc - last_eop_cyc), 3);
                        sop_cyc = cyc;
                    end
                    if (out_eop) begin
                        check_eq("frame_rate", 32'(cyc - sop_cyc), 59);
                        have_eop = 1'b1;
                        last_eop_cyc = cyc;
                    end
                end
            end
            stalled = out_valid && !out_ready;
            held    = cur;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (k < 20000 && (busy || !rx_ptr_fifo_empty || exp_q.size() != 0)) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20000) check_eq("idle_timeout", 32'(k), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_frm_cnt"}, 32'(frm_cnt), 32'(exp_frm));
        check_eq({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
        check_eq({tag, "_drained"}, 32'(data_popped), 32'(data_pushed));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_data"}, 32'(out_data), 0);
        check_eq({tag, "_sop_eop"}, 32'({out_sop, out_eop}), 0);
        check_eq({tag, "_frm"}, 32'(frm_cnt), 0);
        check_eq({tag, "_drop"}, 32'(drop_cnt), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_fsm"}, 32'(fsm_state), 0);
        check_eq({tag, "_rd"}, 32'({rx_ptr_fifo_rd, rx_data_fifo_rd}), 0);
    endtask

    initial begin
        int base;
        int k;
        rstn_sys  = 1'b0;
        out_ready = 1'b0;
        fork
            ready_driver();
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rstn_sys = 1'b1;

        // single 64-byte frame, ready held high
        push_frame(16'h0040, 0);
        wait_idle();
        check_counters("t1");

        // same frame under random back-pressure
        ready_mode = 1;
        push_frame(16'h0040, 0);
        wait_idle();
        check_counters("t2");
        ready_mode = 0;

        // errored frame drained, following frame forwarded
        push_frame(16'h8040, 1);
        push_frame(16'h0040, 0);
        wait_idle();
        check_counters("t3");

        // zero length, oversize, undersize
        push_frame(16'h0000, 2);
        push_frame(16'h05EF, 2);
        push_frame(16'h0020, 2);
        wait_idle();
        check_counters("t4");

        // back-to-back minimum frames: full rate and 2-cycle gap
        have_eop = 1'b0;
        gap_mode = 1'b1;
        for (int i = 0; i < 3; i++) push_frame(16'h003C, 2);
        wait_idle();
        gap_mode = 1'b0;
        check_counters("t5");

        // length boundaries and reserved bits, random back-pressure
        ready_mode = 1;
        push_frame(16'h003B, 2);
        push_frame(16'h7044, 2);
        push_frame(16'h05EE, 2);
        push_frame(16'h8000, 2);
        for (int i = 0; i < 3; i++) push_frame(16'($urandom_range(60, 100)), 2);
        wait_idle();
        check_counters("bounds");
        ready_mode = 0;

        // reset at byte 10 of a frame
        base = n_acc;
        push_frame(16'h0040, 2);
        k = 0;
        while (k < 1000 && n_acc < base + 10) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) check_eq("reset_wait_timeout", 32'(k), 0);
        @(posedge clk);
        #2;
        rstn_sys = 1'b0;
        #1;
        check_reset_state("midreset");
        exp_q.delete();
        exp_frm  = 0;
        exp_drop = 0;
        repeat (2) @(negedge clk);
        rstn_sys = 1'b1;
        push_frame(16'h0040, 2);
        wait_idle();
        check_counters("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
